policy_deck: RTL

- Policy-card deck engine for the SNPU game processor.
- Owns the policy draw stack, the 3-card hand, the discard pile and the board tallies. Executes host commands: peek, draw, discard, enact, shuffle, reset.
- It is the consumer side of the policy-stack / random-source pair. It reads and pops stack bits, and it consumes an internal free-running LFSR during shuffles.
- Sits between the top-level pin decoder, which issues commands, and the status outputs.

---
 rtl/policy_deck.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/policy_deck.sv
// Policy-card deck engine: draw stack, 3-card hand, discard and board tallies,
// host command execution and an LFSR-driven in-place Fisher-Yates shuffle.
module policy_deck #(
   parameter int unsigned DECK_SIZE = 17,
   parameter int unsigned N_LIB     = 6,
   parameter logic [7:0]  LFSR_SEED = 8'h01
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   input  logic [2:0] cmd_op,
   input  logic [1:0] cmd_idx,
   output logic       cmd_ready,
   output logic       rsp_valid,
   output logic       rsp_err,
   output logic [2:0] rsp_cards,
   output logic [4:0] stack_n,
   output logic [4:0] discard_n,
   output logic [1:0] hand_n,
   output logic [2:0] board_lib,
   output logic [2:0] board_fas
);
   localparam int unsigned CW = 5;
   localparam int unsigned SW = CW + 1;
   localparam logic [DECK_SIZE-1:0] INIT_STACK = DECK_SIZE'((64'd1 << N_LIB) - 64'd1);
   localparam logic [CW-1:0] FULL_N = CW'(DECK_SIZE);

   localparam logic [2:0] OP_RESET = 3'd1;
   localparam logic [2:0] OP_PEEK  = 3'd2;
   localparam logic [2:0] OP_DRAW  = 3'd3;
   localparam logic [2:0] OP_DISC  = 3'd4;
   localparam logic [2:0] OP_ENACT = 3'd5;
   localparam logic [2:0] OP_SHUF  = 3'd6;
   localparam logic [2:0] OP_ILL   = 3'd7;

   typedef enum logic [1:0] {IDLE, MERGE, SWAP, DONE} state_t;

   state_t                state;
   logic [DECK_SIZE-1:0]  stack;
   logic [DECK_SIZE-1:0]  merge_c;
   logic [DECK_SIZE-1:0]  swapped_c;
   logic [CW-1:0]         discard_ones;
   logic [CW-1:0]         swap_i;
   logic [CW-1:0]         new_n_c;
   logic [CW-1:0]         r_c;
   logic [SW-1:0]         merge_top_c;
   logic [2:0]            hand;
   logic [1:0]            kept_c;
   logic                  illegal_c;
   logic                  disc_card_c;
   logic                  card_c;
   logic                  other_c;
   logic [7:0]            lfsr;

   // Free-running random source, independent of the deck state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr <= LFSR_SEED;
      else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end

   assign r_c         = lfsr[4:0];
   assign new_n_c     = stack_n + discard_n;
   assign merge_top_c = SW'(stack_n) + SW'(discard_ones);
   assign disc_card_c = hand[cmd_idx];
   assign card_c      = hand[{1'b0, cmd_idx[0]}];
   assign other_c     = hand[{1'b0, ~cmd_idx[0]}];

   always_comb begin
      illegal_c = 1'b0;
      case (cmd_op)
         OP_PEEK:  illegal_c = (stack_n < CW'(3));
         OP_DRAW:  illegal_c = (stack_n < CW'(3)) || (hand_n != 2'd0);
         OP_DISC:  illegal_c = (hand_n != 2'd3) || (cmd_idx > 2'd2);
         OP_ENACT: illegal_c = (hand_n != 2'd2) || (cmd_idx > 2'd1);
         OP_SHUF:  illegal_c = (hand_n != 2'd0);
         OP_ILL:   illegal_c = 1'b1;
         default:  illegal_c = 1'b0;
      endcase
   end

   // Surviving two cards keep their relative order
   always_comb begin
      case (cmd_idx)
         2'd0:    kept_c = hand[2:1];
         2'd1:    kept_c = {hand[2], hand[0]};
         default: kept_c = hand[1:0];
      endcase
   end

   // Discarded liberals are packed as ones directly above the current top count
   always_comb begin
      merge_c = stack;
      for (int k = 0; k < DECK_SIZE; k++) begin
         if (SW'(k) >= SW'(stack_n) && SW'(k) < merge_top_c) merge_c[k] = 1'b1;
      end
   end

   always_comb begin
      swapped_c         = stack;
      swapped_c[swap_i] = stack[r_c];
      swapped_c[r_c]    = stack[swap_i];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         stack        <= INIT_STACK;
         stack_n      <= FULL_N;
         discard_n    <= '0;
         discard_ones <= '0;
         hand         <= '0;
         hand_n       <= '0;
         board_lib    <= '0;
         board_fas    <= '0;
         swap_i       <= '0;
         rsp_valid    <= 1'b0;
         rsp_err      <= 1'b0;
         rsp_cards    <= '0;
         cmd_ready    <= 1'b1;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready && cmd_op != 3'd0) begin
                  rsp_valid <= (cmd_op != OP_SHUF) || illegal_c;
                  rsp_err   <= illegal_c;
                  rsp_cards <= '0;
                  if (!illegal_c) begin
                     case (cmd_op)
                        OP_RESET: begin
                           stack        <= INIT_STACK;
                           stack_n      <= FULL_N;
                           discard_n    <= '0;
                           discard_ones <= '0;
                           hand         <= '0;
                           hand_n       <= '0;
                           board_lib    <= '0;
                           board_fas    <= '0;
                        end
                        OP_PEEK: rsp_cards <= stack[2:0];
                        OP_DRAW: begin
                           hand      <= stack[2:0];
                           stack     <= stack >> 3;
                           stack_n   <= stack_n - CW'(3);
                           hand_n    <= 2'd3;
                           rsp_cards <= stack[2:0];
                        end
                        OP_DISC: begin
                           discard_n    <= discard_n + CW'(1);
                           discard_ones <= discard_ones + CW'(disc_card_c);
                           hand         <= {1'b0, kept_c};
                           hand_n       <= 2'd2;
                           rsp_cards    <= {1'b0, kept_c};
                        end
                        OP_ENACT: begin
                           if (card_c) board_lib <= (board_lib == 3'd7) ? board_lib : board_lib + 3'd1;
                           else        board_fas <= (board_fas == 3'd7) ? board_fas : board_fas + 3'd1;
                           discard_n    <= discard_n + CW'(1);
                           discard_ones <= discard_ones + CW'(other_c);
                           hand         <= '0;
                           hand_n       <= '0;
                           rsp_cards    <= {2'b00, card_c};
                        end
                        OP_SHUF: begin
                           cmd_ready <= 1'b0;
                           state     <= MERGE;
                        end
                        default: ;
                     endcase
                  end
               end
            end
            MERGE: begin
               stack        <= merge_c;
               stack_n      <= new_n_c;
               discard_n    <= '0;
               discard_ones <= '0;
               swap_i       <= new_n_c - CW'(1);
               if (new_n_c <= CW'(1)) begin
                  state     <= DONE;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_cards <= '0;
               end else begin
                  state <= SWAP;
               end
            end
            SWAP: begin
               // Out-of-range draws are rejected rather than folded, keeping the shuffle unbiased
               if (r_c <= swap_i) begin
                  stack  <= swapped_c;
                  swap_i <= swap_i - CW'(1);
                  if (swap_i == CW'(1)) begin
                     state     <= DONE;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b0;
                     rsp_cards <= '0;
                  end
               end
            end
            DONE: begin
               cmd_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
